// File: rtl/mc_controller_pkg.sv
// Shared types and constants for the multicycle MIPS main controller.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_BLEEX,
        S_ADDIEX,
        S_ADDIWB,
        S_JEX
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLE   = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_SGT   = 2'b10;
    localparam logic [1:0] ALUOP_FUNCT = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_word_t;

endpackage

// File: rtl/mc_controller_if.sv
// Datapath-facing bundle of the main controller: status inputs and control outputs.
interface mc_controller_if;
    logic [5:0] op;
    logic       zero;
    logic       memready;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcen;

    modport master (
        input  op, zero, memready,
        output iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, aluop, pcsrc, pcen
    );

    modport slave (
        output op, zero, memready,
        input  iord, memwrite, irwrite, regwrite, regdst, memtoreg,
               alusrca, alusrcb, aluop, pcsrc, pcen
    );
endinterface

// File: rtl/mc_controller_outdec.sv
// Combinational state-to-control-word decoder (Moore outputs, FETCH gated by memready).
module mc_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     state_i,
    input  logic       memready_i,
    output ctrl_word_t ctrl_o
);

    // Per-state control word; everything not named stays deasserted.
    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.alusrcb = SRCB_FOUR;
                ctrl_o.irwrite = memready_i;
                ctrl_o.pcwrite = memready_i;
            end
            S_DECODE:  ctrl_o.alusrcb = SRCB_IMM2;
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
            end
            S_MEMRD:   ctrl_o.iord = 1'b1;
            S_MEMWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_BEQEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.branch  = 1'b1;
            end
            S_BLEEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SGT;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.branch  = 1'b1;
            end
            S_ADDIWB:  ctrl_o.regwrite = 1'b1;
            S_JEX: begin
                ctrl_o.pcsrc   = PCSRC_JUMP;
                ctrl_o.pcwrite = 1'b1;
            end
            default:   ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: state register, next-state logic and output gating.
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mc_controller_if.master bus
);

    state_t     state_q, state_d;
    ctrl_word_t ctrl;

    // State register; low reset forces FETCH immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state logic; unknown opcodes fall back to FETCH from DECODE.
    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:   state_d = bus.memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_BLE:       state_d = S_BLEEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = bus.memready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = bus.memready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state_i    (state_q),
        .memready_i (bus.memready),
        .ctrl_o     (ctrl)
    );

    // Selects follow the decoded word; write enables are also masked by reset
    // because FETCH's irwrite/pcwrite track memready even while held in reset.
    always_comb begin
        bus.iord     = ctrl.iord;
        bus.regdst   = ctrl.regdst;
        bus.memtoreg = ctrl.memtoreg;
        bus.alusrca  = ctrl.alusrca;
        bus.alusrcb  = ctrl.alusrcb;
        bus.aluop    = ctrl.aluop;
        bus.pcsrc    = ctrl.pcsrc;
        bus.memwrite = ctrl.memwrite & reset;
        bus.irwrite  = ctrl.irwrite & reset;
        bus.regwrite = ctrl.regwrite & reset;
        bus.pcen     = (ctrl.pcwrite | (ctrl.branch & bus.zero)) & reset;
    end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller against a table-driven instruction model.
module tb_mc_controller;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mc_controller_if ifc();

    mc_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    always #5 clk = ~clk;

    // Instruction phases as named in the controller description.
    typedef enum int {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_RE, P_RW,
                      P_BEQ, P_BLE, P_AE, P_AW, P_J} ph_e;

    // Observed vector: [13]iord [12]memwrite [11]irwrite [10]regwrite [9]regdst
    // [8]memtoreg [7]alusrca [6:5]alusrcb [4:3]aluop [2:1]pcsrc [0]pcen
    logic [13:0] got_q[$];
    logic [13:0] exp_q[$];

    function automatic logic [13:0] obs();
        return {ifc.iord, ifc.memwrite, ifc.irwrite, ifc.regwrite, ifc.regdst,
                ifc.memtoreg, ifc.alusrca, ifc.alusrcb, ifc.aluop, ifc.pcsrc, ifc.pcen};
    endfunction

    // Expected outputs for one phase, straight from the per-state output table.
    function automatic logic [13:0] model(ph_e ph, logic mr, logic z);
        logic iord, mw, irw, rw, rd, m2r, sa, pcen;
        logic [1:0] sb, ao, ps;
        {iord, mw, irw, rw, rd, m2r, sa, pcen} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (ph)
            P_F:   begin sb = 2'b01; irw = mr; pcen = mr; end
            P_D:   sb = 2'b11;
            P_MA, P_AE: begin sa = 1'b1; sb = 2'b10; end
            P_MR:  iord = 1'b1;
            P_MWB: begin rw = 1'b1; m2r = 1'b1; end
            P_MW:  begin iord = 1'b1; mw = 1'b1; end
            P_RE:  begin sa = 1'b1; ao = 2'b11; end
            P_RW:  begin rd = 1'b1; rw = 1'b1; end
            P_BEQ: begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pcen = z; end
            P_BLE: begin sa = 1'b1; ao = 2'b10; ps = 2'b01; pcen = z; end
            P_AW:  rw = 1'b1;
            P_J:   begin ps = 2'b10; pcen = 1'b1; end
            default: ;
        endcase
        return {iord, mw, irw, rw, rd, m2r, sa, sb, ao, ps, pcen};
    endfunction

    // Cycles per instruction without stalls.
    function automatic int seq_len(logic [5:0] op);
        case (op)
            OP_LW:                     return 5;
            OP_SW, OP_RTYPE, OP_ADDI:  return 4;
            OP_BEQ, OP_BLE, OP_J:      return 3;
            default:                   return 2;
        endcase
    endfunction

    function automatic ph_e phase_at(logic [5:0] op, int i);
        if (i == 0) return P_F;
        if (i == 1) return P_D;
        if (i == 2) begin
            case (op)
                OP_LW, OP_SW: return P_MA;
                OP_RTYPE:     return P_RE;
                OP_ADDI:      return P_AE;
                OP_BEQ:       return P_BEQ;
                OP_BLE:       return P_BLE;
                default:      return P_J;
            endcase
        end
        if (i == 3) begin
            case (op)
                OP_LW:    return P_MR;
                OP_SW:    return P_MW;
                OP_RTYPE: return P_RW;
                default:  return P_AW;
            endcase
        end
        return P_MWB;
    endfunction

    // Runs one instruction from FETCH, logging observed and modelled outputs per cycle.
    task automatic exec_instr(input logic [5:0] op, input logic zin,
                              input int mem_stalls, input int fetch_stalls, input bit rnd);
        ph_e ph;
        int  stalls;
        logic mr, z;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < seq_len(op); i++) begin
            ph = phase_at(op, i);
            if (ph == P_F)                     stalls = rnd ? int'($urandom_range(0, 3)) : fetch_stalls;
            else if (ph == P_MR || ph == P_MW) stalls = rnd ? int'($urandom_range(0, 3)) : mem_stalls;
            else                               stalls = 0;
            for (int k = 0; k <= stalls; k++) begin
                if (ph == P_F || ph == P_MR || ph == P_MW) mr = (k == stalls);
                else mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                z = rnd ? 1'($urandom_range(0, 1)) : zin;
                ifc.op = op; ifc.memready = mr; ifc.zero = z;
                #1;
                got_q.push_back(obs());
                exp_q.push_back(model(ph, mr, z));
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        logic [13:0] g;
        reset = 1'b0; ifc.op = OP_LW; ifc.memready = 1'b1; ifc.zero = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        g = obs();
        checks++;
        if (g !== 14'b0000000_01_00_00_0) begin
            errors++; $display("FAIL reset_hold got=%b want=%b", g, 14'b0000000_01_00_00_0);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        ifc.memready = 1'b0; #1;
        g = obs();
        checks++;
        if (g !== model(P_MR, 1'b0, 1'b1)) begin
            errors++; $display("FAIL reach_memrd got=%b want=%b", g, model(P_MR, 1'b0, 1'b1));
        end
        reset = 1'b0; #1;
        g = obs();
        checks++;
        if (g !== 14'b0000000_01_00_00_0) begin
            errors++; $display("FAIL reset_mid_memrd got=%b want=%b", g, 14'b0000000_01_00_00_0);
        end
        ifc.memready = 1'b1; reset = 1'b1; #1;
        g = obs();
        checks++;
        if (g[11] !== 1'b1 || g[0] !== 1'b1 || g[10] !== 1'b0 || g[13] !== 1'b0) begin
            errors++; $display("FAIL release_fetch got=%b want irwrite=1 pcen=1 regwrite=0 iord=0", g);
        end
        @(posedge clk); #1;
        ifc.op = 6'b111111; #1;
        g = obs();
        checks++;
        if (g !== model(P_D, 1'b1, 1'b1)) begin
            errors++; $display("FAIL restart_decode got=%b want=%b", g, model(P_D, 1'b1, 1'b1));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        exec_instr(OP_LW, 1'b0, 0, 0, 1'b0);
        checks++;
        if (got_q.size() != 5) begin errors++; $display("FAIL lw_cycles got=%0d want=5", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL lw_cycle%0d got=%b want=%b", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q[4][10] !== 1'b1 || got_q[4][8] !== 1'b1 || got_q[3][10] !== 1'b0) begin
            errors++; $display("FAIL lw_writeback c4=%b c3=%b want regwrite/memtoreg only in cycle 5", got_q[4], got_q[3]);
        end
    endtask

    task automatic test_sw_stall();
        int n_mw;
        logic [13:0] g;
        exec_instr(OP_SW, 1'b0, 2, 0, 1'b0);
        n_mw = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL sw_cycle%0d got=%b want=%b", i, got_q[i], exp_q[i]);
            end
            if (got_q[i][12] === 1'b1) n_mw++;
        end
        checks++;
        if (got_q.size() != 6 || n_mw != 3 || got_q[3][12] !== 1'b1 || got_q[5][12] !== 1'b1) begin
            errors++; $display("FAIL sw_memwrite_run cycles=%0d memwrite_cycles=%0d want 6 and 3", got_q.size(), n_mw);
        end
        ifc.memready = 1'b0; #1;
        g = obs();
        checks++;
        if (g !== model(P_F, 1'b0, ifc.zero)) begin
            errors++; $display("FAIL sw_back_to_fetch got=%b want=%b", g, model(P_F, 1'b0, ifc.zero));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        exec_instr(OP_RTYPE, 1'b0, 0, 1, 1'b0);
        checks++;
        if (got_q.size() != 5) begin errors++; $display("FAIL rtype_cycles got=%0d want=5", got_q.size()); end
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rtype_cycle%0d got=%b want=%b", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q[3][4:3] !== 2'b11 || got_q[4][9] !== 1'b1 || got_q[4][10] !== 1'b1) begin
            errors++; $display("FAIL rtype_ctrl ex=%b wb=%b want aluop=11 then regdst=regwrite=1", got_q[3], got_q[4]);
        end
    endtask

    task automatic test_ble();
        for (int zz = 1; zz >= 0; zz--) begin
            exec_instr(OP_BLE, 1'(zz), 0, 0, 1'b0);
            checks++;
            if (got_q.size() != 3) begin errors++; $display("FAIL ble_cycles z=%0d got=%0d want=3", zz, got_q.size()); end
            for (int i = 0; i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL ble_z%0d_cycle%0d got=%b want=%b", zz, i, got_q[i], exp_q[i]);
                end
            end
            checks++;
            if (got_q[2][4:3] !== 2'b10 || got_q[2][2:1] !== 2'b01 || got_q[2][0] !== 1'(zz)) begin
                errors++; $display("FAIL ble_ex_z%0d got=%b want aluop=10 pcsrc=01 pcen=%0d", zz, got_q[2], zz);
            end
        end
    endtask

    task automatic test_illegal_j();
        exec_instr(6'b111111, 1'b1, 0, 0, 1'b0);
        checks++;
        if (got_q.size() != 2 || got_q[1] !== 14'b0000000_11_00_00_0) begin
            errors++; $display("FAIL illegal_op cycles=%0d decode=%b want 2 and %b", got_q.size(), got_q[1], 14'b0000000_11_00_00_0);
        end
        ifc.memready = 1'b0; #1;
        checks++;
        if (obs() !== model(P_F, 1'b0, ifc.zero)) begin
            errors++; $display("FAIL illegal_back_to_fetch got=%b want=%b", obs(), model(P_F, 1'b0, ifc.zero));
        end
        exec_instr(OP_J, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL j_cycle%0d got=%b want=%b", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (got_q.size() != 3 || got_q[2][2:1] !== 2'b10 || got_q[2][0] !== 1'b1) begin
            errors++; $display("FAIL j_ex cycles=%0d got=%b want pcsrc=10 pcen=1", got_q.size(), got_q[got_q.size()-1]);
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [8];
        logic [5:0] op;
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_BLE, OP_ADDI, OP_J, 6'b111111};
        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, 7)];
            if (op == 6'b111111) op = 6'($urandom_range(0, 63));
            exec_instr(op, 1'b0, 0, 0, 1'b1);
            for (int i = 0; i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand_n%0d_op%b_cycle%0d got=%b want=%b", n, op, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        ifc.op = '0; ifc.zero = 1'b0; ifc.memready = 1'b0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_rtype();
        test_ble();
        test_illegal_j();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle main controller that sequences the shared ALU, register file and unified memory of the multicycle MIPS core. A Moore FSM walks each instruction through fetch, decode, execute, memory and writeback, and drives the 2-bit `aluop` into the existing ALU decoder alongside the mux selects and write enables. It stalls on a memory-ready handshake so one ALU and one memory port serve every instruction phase.

## Interface
Parameters:
- none; opcodes, states and `aluop` codes are fixed in `mc_ctrl_pkg`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `op`  in  6  opcode field, `instr[31:26]`, from the instruction register.
- `zero`  in  1  ALU zero flag.
- `memready`  in  1  memory completes the current access this cycle.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  memory write strobe.
- `irwrite`  out  1  instruction register load.
- `regwrite`  out  1  register file write.
- `regdst`  out  1  write register select: 1 = rd, 0 = rt.
- `memtoreg`  out  1  writeback data select: 1 = data register, 0 = ALUOut.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `aluop`  out  2  to the ALU decoder: 00 = add, 01 = sub, 10 = sgt, 11 = R-type funct.
- `pcsrc`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `pcen`  out  1  PC enable, equal to `pcwrite | (branch & zero)`.

## Operation
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, ble 000110, addi 001000, j 000010. Any other opcode is a no-op: DECODE returns to FETCH.
- States and transitions:
  - FETCH: go to DECODE when `memready`, otherwise hold.
  - DECODE: branch on `op`.
  - MEMADR: go to MEMRD for lw, MEMWR for sw.
  - MEMRD: go to MEMWB when `memready`, otherwise hold.
  - MEMWB: go to FETCH.
  - MEMWR: go to FETCH when `memready`, otherwise hold.
  - RTYPEEX: go to RTYPEWB, then FETCH.
  - ADDIEX: go to ADDIWB, then FETCH.
  - BEQEX, BLEEX, JEX: go to FETCH.
- Asserted outputs per state (all unlisted outputs are 0):
  - FETCH: `alusrcb`=01, `irwrite`=`pcwrite`=`memready`.
  - DECODE: `alusrcb`=11.
  - MEMADR and ADDIEX: `alusrca`=1, `alusrcb`=10.
  - MEMRD: `iord`=1.
  - MEMWB: `regwrite`=1, `memtoreg`=1.
  - MEMWR: `iord`=1, `memwrite`=1 (held until `memready`).
  - RTYPEEX: `alusrca`=1, `aluop`=11.
  - RTYPEWB: `regdst`=1, `regwrite`=1.
  - BEQEX: `alusrca`=1, `aluop`=01, `pcsrc`=01, `branch`=1.
  - BLEEX: `alusrca`=1, `aluop`=10, `pcsrc`=01, `branch`=1. The ALU computes a>b, so `zero`=1 means a≤b and the branch is taken.
  - ADDIWB: `regwrite`=1.
  - JEX: `pcsrc`=10, `pcwrite`=1.
- `branch` and `pcwrite` are internal signals; only `pcen` leaves the block.

## Timing
- Outputs are Moore: decoded from the state register only, except `irwrite`/`pcwrite` in FETCH (gated by `memready`) and `pcen` (uses `zero`).
- Reset asserted (low): state forced to FETCH immediately. All write enables (`memwrite`, `irwrite`, `regwrite`, `pcen`) forced to 0; selects take their FETCH values.
- Reset released mid-instruction: the aborted instruction is discarded and fetch restarts. No partial write occurs after the release edge.
- Cycles per instruction with `memready` held at 1:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, ble, j: 3
- Each cycle `memready` is low in FETCH, MEMRD or MEMWR adds one cycle. The `memwrite` level is held stable across the stall.

## Structure
- `mc_ctrl_pkg` holds:
  - `state_t` enum (13 states, 4-bit encoding);
  - opcode localparams;
  - `aluop` codes;
  - a packed `ctrl_word_t` struct for the state-to-output decode.
- Optional sub-module `mc_outdec`: a purely combinational state-to-`ctrl_word_t` decoder. It keeps the FSM file limited to the state register and next-state logic.

## Test plan
- Reset low mid-MEMRD, then high with `memready`=1 → state FETCH, `irwrite`=1, `pcen`=1, `regwrite`=0 on the first cycle.
- lw (op 100011), `memready`=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; `regwrite`=1 and `memtoreg`=1 only in cycle 5.
- sw with `memready` low for 2 cycles in MEMWR → `memwrite`=1 for 3 consecutive cycles, then FETCH.
- R-type (op 000000) → `aluop`=11 in RTYPEEX; `regdst`=1 and `regwrite`=1 in RTYPEWB; 4 cycles total.
- ble (op 000110):
  - `zero`=1 → `aluop`=10, `pcsrc`=01, `pcen`=1;
  - `zero`=0 → `pcen`=0.
  - Both take 3 cycles.
- Illegal op 111111 → DECODE, then FETCH, with no write enable asserted outside FETCH. j (op 000010) → `pcsrc`=10, `pcen`=1 in JEX.
